// File: rtl/gaussian_window_gen.sv
// Streaming 3x3 window generator feeding the Gaussian blur kernel: two line buffers plus a column shift register.
// Optional macro WINDOW_COORD_EN adds out_x/out_y ports carrying the window centre coordinates.
module gaussian_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] out_window,
  output logic        out_last
`ifdef WINDOW_COORD_EN
  ,
  output logic [15:0] out_x,
  output logic [15:0] out_y
`endif
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  // Column layout: [7:0] = line y-2 (top), [15:8] = line y-1, [23:16] = current line.
  function automatic logic [71:0] pack_window(input logic [23:0] c0,
                                              input logic [23:0] c1,
                                              input logic [23:0] c2);
    return {c2[23:16], c1[23:16], c0[23:16],
            c2[15:8],  c1[15:8],  c0[15:8],
            c2[7:0],   c1[7:0],   c0[7:0]};
  endfunction

  logic [7:0]    lb1_r [IMG_WIDTH];
  logic [7:0]    lb2_r [IMG_WIDTH];
  logic [23:0]   col_c0_r;
  logic [23:0]   col_c1_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          out_valid_r;
  logic          out_last_r;
  logic [71:0]   win_r;
`ifdef WINDOW_COORD_EN
  logic [15:0]   out_x_r;
  logic [15:0]   out_y_r;
`endif

  logic          in_ready_s;
  logic          accept_s;
  logic          emit_s;
  logic          last_s;
  logic [7:0]    lb1_rd_s;
  logic [7:0]    lb2_rd_s;
  logic [23:0]   new_col_s;
  logic [71:0]   window_s;
  logic [XW-1:0] x_next_s;
  logic [YW-1:0] y_next_s;

  assign in_ready_s = !out_valid_r || out_ready;
  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign out_window = win_r;
`ifdef WINDOW_COORD_EN
  assign out_x = out_x_r;
  assign out_y = out_y_r;
`endif

  // Handshake, raster counters and the candidate window for the current accept.
  always_comb begin
    lb1_rd_s  = lb1_r[x_r];
    lb2_rd_s  = lb2_r[x_r];
    new_col_s = {in_pixel, lb1_rd_s, lb2_rd_s};
    window_s  = pack_window(col_c0_r, col_c1_r, new_col_s);
    accept_s  = in_valid && in_ready_s;
    last_s    = (x_r == X_LAST) && (y_r == Y_LAST);
    emit_s    = accept_s && (x_r >= X_TWO) && (y_r >= Y_TWO);
    x_next_s  = x_r;
    y_next_s  = y_r;
    if (x_r == X_LAST) begin
      x_next_s = {XW{1'b0}};
      if (y_r == Y_LAST) begin
        y_next_s = {YW{1'b0}};
      end else begin
        y_next_s = y_r + YW'(1);
      end
    end else begin
      x_next_s = x_r + XW'(1);
    end
  end

  // Line buffers and column shift register; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb2_r[x_r] <= lb1_rd_s;
      lb1_r[x_r] <= in_pixel;
      col_c0_r   <= col_c1_r;
      col_c1_r   <= new_col_s;
    end else begin
      col_c0_r   <= col_c0_r;
      col_c1_r   <= col_c1_r;
    end
  end

  // Counters and the registered output stage; a new window may replace one being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      win_r       <= 72'd0;
`ifdef WINDOW_COORD_EN
      out_x_r     <= 16'd0;
      out_y_r     <= 16'd0;
`endif
    end else begin
      if (accept_s) begin
        x_r <= x_next_s;
        y_r <= y_next_s;
      end
      if (emit_s) begin
        out_valid_r <= 1'b1;
        out_last_r  <= last_s;
        win_r       <= window_s;
`ifdef WINDOW_COORD_EN
        out_x_r     <= 16'(x_r) - 16'd1;
        out_y_r     <= 16'(y_r) - 16'd1;
`endif
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_window_gen.sv
// Scoreboard bench for gaussian_window_gen: a 4x4 instance for directed streams and a 5x3 instance
// for randomly toggled handshakes; expectations are hand-computed windows queued at stimulus time.
module tb_gaussian_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_in_pixel;
  logic [71:0] a_out_window;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_in_pixel;
  logic [71:0] b_out_window;
`ifdef WINDOW_COORD_EN
  logic [15:0] a_out_x, a_out_y, b_out_x, b_out_y;
`endif

  gaussian_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pixel(a_in_pixel),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_window(a_out_window), .out_last(a_out_last)
`ifdef WINDOW_COORD_EN
    , .out_x(a_out_x), .out_y(a_out_y)
`endif
  );

  gaussian_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_window(b_out_window), .out_last(b_out_last)
`ifdef WINDOW_COORD_EN
    , .out_x(b_out_x), .out_y(b_out_y)
`endif
  );

  typedef struct {
    logic [71:0] win;
    logic        last;
    int          cx;
    int          cy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;
  int a_wins = 0;
  int a_lasts = 0;
  int b_wins = 0;
  int b_lasts = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] w9(input int b0, input int b1, input int b2,
                                     input int b3, input int b4, input int b5,
                                     input int b6, input int b7, input int b8);
    return {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  task automatic push_a(input logic [71:0] w, input logic last, input int cx, input int cy);
    exp_t e;
    e.win = w; e.last = last; e.cx = cx; e.cy = cy;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [71:0] w, input logic last, input int cx, input int cy);
    exp_t e;
    e.win = w; e.last = last; e.cx = cx; e.cy = cy;
    qb.push_back(e);
  endtask

  // 4x4 frame with every pixel raised by o
  task automatic push_frame_a(input int o);
    push_a(w9(o+0, o+1, o+2, o+4, o+5, o+6, o+8, o+9, o+10),    1'b0, 1, 1);
    push_a(w9(o+1, o+2, o+3, o+5, o+6, o+7, o+9, o+10, o+11),   1'b0, 2, 1);
    push_a(w9(o+4, o+5, o+6, o+8, o+9, o+10, o+12, o+13, o+14), 1'b0, 1, 2);
    push_a(w9(o+5, o+6, o+7, o+9, o+10, o+11, o+13, o+14, o+15), 1'b1, 2, 2);
  endtask

  task automatic send_a(input logic [7:0] p);
    int waited = 0;
    bit done = 0;
    a_in_pixel = p;
    a_in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (a_in_ready) begin
        done = 1;
      end else if (waited > 200) begin
        checks++; errors++;
        $display("FAIL a_send_timeout: pixel %0d not accepted after %0d cycles", p, waited);
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p);
    int waited = 0;
    bit done = 0;
    b_in_pixel = p;
    b_in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (b_in_ready) begin
        done = 1;
      end else if (waited > 200) begin
        checks++; errors++;
        $display("FAIL b_send_timeout: pixel %0d not accepted after %0d cycles", p, waited);
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a(input string name);
    int n = 0;
    while (qa.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check(name, 72'(qa.size()), 72'd0);
  endtask

  // Monitor A: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      a_wins++;
      if (a_out_last) a_lasts++;
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: window %h with no expectation", a_out_window);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_window", a_out_window, e.win);
        check("a_last", 72'(a_out_last), 72'(e.last));
`ifdef WINDOW_COORD_EN
        check("a_out_x", 72'(a_out_x), 72'(e.cx));
        check("a_out_y", 72'(a_out_y), 72'(e.cy));
`endif
      end
    end
  end

  logic        b_stalled = 1'b0;
  logic [71:0] b_held;

  // Monitor B: scoreboard plus output stability across stalls
  always @(negedge clk) begin
    if (!rst) begin
      if (b_stalled) begin
        check("b_hold_valid", 72'(b_out_valid), 72'd1);
        check("b_hold_window", b_out_window, b_held);
      end
      b_stalled = b_out_valid && !b_out_ready;
      b_held    = b_out_window;
      if (b_out_valid && b_out_ready) begin
        b_wins++;
        if (b_out_last) b_lasts++;
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: window %h with no expectation", b_out_window);
        end else begin
          exp_t e;
          e = qb.pop_front();
          check("b_window", b_out_window, e.win);
          check("b_last", 72'(b_out_last), 72'(e.last));
`ifdef WINDOW_COORD_EN
          check("b_out_x", 72'(b_out_x), 72'(e.cx));
          check("b_out_y", 72'(b_out_y), 72'(e.cy));
`endif
        end
      end
    end else begin
      b_stalled = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [71:0] first_win;
    int          wins0;
    int          lasts0;
    bit          b_run;
    first_win = w9(0, 1, 2, 4, 5, 6, 8, 9, 10);

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_pixel = 8'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_pixel = 8'd0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_a_valid", 72'(a_out_valid), 72'd0);
    check("reset_a_last", 72'(a_out_last), 72'd0);
    check("reset_a_window", a_out_window, 72'd0);
    check("reset_a_in_ready", 72'(a_in_ready), 72'd1);
    check("reset_b_valid", 72'(b_out_valid), 72'd0);
    check("reset_b_window", b_out_window, 72'd0);
`ifdef WINDOW_COORD_EN
    check("reset_a_x", 72'(a_out_x), 72'd0);
    check("reset_a_y", 72'(a_out_y), 72'd0);
`endif

    // Basic stream
    wins0 = a_wins; lasts0 = a_lasts;
    push_frame_a(0);
    for (int i = 0; i < 10; i++) send_a(8'(i));
    check("basic_no_early_window", 72'(a_wins - wins0), 72'd0);
    send_a(8'd10);
    check("basic_latency_valid", 72'(a_out_valid), 72'd1);
    check("basic_latency_window", a_out_window, first_win);
    for (int i = 11; i < 16; i++) send_a(8'(i));
    drain_a("basic_drain");
    check("basic_count", 72'(a_wins - wins0), 72'd4);
    check("basic_lasts", 72'(a_lasts - lasts0), 72'd1);

    // Backpressure on the first window
    wins0 = a_wins;
    a_out_ready = 1'b0;
    push_frame_a(0);
    fork
      begin
        for (int i = 0; i < 16; i++) send_a(8'(i));
      end
      begin
        int n = 0;
        while (!a_out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("stall_seen", 72'(a_out_valid), 72'd1);
        for (int k = 0; k < 3; k++) begin
          check("stall_window", a_out_window, first_win);
          check("stall_in_ready", 72'(a_in_ready), 72'd0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    drain_a("stall_drain");
    check("stall_count", 72'(a_wins - wins0), 72'd4);

    // Back-to-back frames, second frame offset by 16
    wins0 = a_wins; lasts0 = a_lasts;
    push_frame_a(0);
    push_frame_a(16);
    for (int i = 0; i < 32; i++) send_a(8'(i));
    drain_a("b2b_drain");
    check("b2b_count", 72'(a_wins - wins0), 72'd8);
    check("b2b_lasts", 72'(a_lasts - lasts0), 72'd2);

    // Reset in the middle of a frame
    wins0 = a_wins;
    for (int i = 0; i < 6; i++) send_a(8'(i));
    check("midreset_no_valid", 72'(a_out_valid), 72'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_after_valid", 72'(a_out_valid), 72'd0);
    push_frame_a(0);
    for (int i = 0; i < 16; i++) send_a(8'(i));
    drain_a("midreset_drain");
    check("midreset_count", 72'(a_wins - wins0), 72'd4);

    // 5x3 stream with random input gaps and random out_ready
    push_b(w9(0, 1, 2, 5, 6, 7, 10, 11, 12), 1'b0, 1, 1);
    push_b(w9(1, 2, 3, 6, 7, 8, 11, 12, 13), 1'b0, 2, 1);
    push_b(w9(2, 3, 4, 7, 8, 9, 12, 13, 14), 1'b1, 3, 1);
    b_run = 1;
    fork
      begin
        for (int i = 0; i < 15; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_b(8'(i));
        end
        b_run = 0;
      end
      begin
        while (b_run) begin
          b_out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        b_out_ready = 1'b1;
      end
    join
    begin
      int n = 0;
      while (qb.size() != 0 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    check("rand_drain", 72'(qb.size()), 72'd0);
    check("rand_count", 72'(b_wins), 72'd3);
    check("rand_lasts", 72'(b_lasts), 72'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
